// File: rtl/four_sel.sv
// four_sel: 4:1 data selector with a registered output copy and
// select-change tracking.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   en         update enable for y_q, sel_q, sel_chg and chg_cnt
//   a, b, c, d data inputs, chosen by sel = 00 / 01 / 10 / 11
//   sel        source select
//   y          combinational selected data, valid during reset
//   y_q        selected data, registered one enabled cycle later
//   sel_onehot combinational one-hot decode of sel
//   sel_chg    one-cycle pulse after an enabled edge that saw sel change
//   chg_cnt    saturating count of select changes
module four_sel #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [3:0]       sel_onehot,
  output logic             sel_chg,
  output logic [CNT_W-1:0] chg_cnt
);

  // Last select captured on an enabled edge; this is the reference a
  // change is detected against, so edits made while en=0 still count.
  logic [1:0] sel_q;
  logic       sel_diff;

  always_comb begin
    y = a;
    case (sel)
      2'b00:   y = a;
      2'b01:   y = b;
      2'b10:   y = c;
      default: y = d;
    endcase
  end

  assign sel_onehot = 4'b0001 << sel;
  assign sel_diff   = (sel != sel_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      sel_q   <= 2'b00;
      sel_chg <= 1'b0;
      chg_cnt <= '0;
    end else if (en) begin
      y_q     <= y;
      sel_q   <= sel;
      sel_chg <= sel_diff;
      // Counter sticks at all-ones until the next reset.
      if (sel_diff && (chg_cnt != {CNT_W{1'b1}}))
        chg_cnt <= chg_cnt + CNT_W'(1);
    end else begin
      sel_chg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_four_sel.sv
// Bench for four_sel: two instances (8-bit data / 8-bit counter and
// 1-bit data / 2-bit counter) share control inputs and are compared
// against a cycle-level reference model.
module tb_four_sel;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] sel;
  logic [7:0] d8 [4];
  logic       d1 [4];

  logic [7:0] y8, y_q8;
  logic [3:0] oh8;
  logic       chg8;
  logic [7:0] cnt8;

  logic       y1, y_q1;
  logic [3:0] oh1;
  logic       chg1;
  logic [1:0] cnt1;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  int m_sel_q;
  int m_yq8, m_yq1;
  int m_chg;
  int m_cnt8, m_cnt1;

  four_sel #(.WIDTH(8), .CNT_W(8)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .a(d8[0]), .b(d8[1]), .c(d8[2]), .d(d8[3]), .sel(sel),
    .y(y8), .y_q(y_q8), .sel_onehot(oh8), .sel_chg(chg8), .chg_cnt(cnt8)
  );

  four_sel #(.WIDTH(1), .CNT_W(2)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .a(d1[0]), .b(d1[1]), .c(d1[2]), .d(d1[3]), .sel(sel),
    .y(y1), .y_q(y_q1), .sel_onehot(oh1), .sel_chg(chg1), .chg_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel_q = 0;
    m_yq8   = 0;
    m_yq1   = 0;
    m_chg   = 0;
    m_cnt8  = 0;
    m_cnt1  = 0;
  endtask

  task automatic check_all();
    int s;
    s = int'(sel);
    chk("y8",       32'(y8),   32'(d8[s]));
    chk("y1",       32'(y1),   32'(d1[s]));
    chk("onehot8",  32'(oh8),  32'(1 << s));
    chk("onehot1",  32'(oh1),  32'(1 << s));
    chk("y_q8",     32'(y_q8), 32'(m_yq8));
    chk("y_q1",     32'(y_q1), 32'(m_yq1));
    chk("sel_chg8", 32'(chg8), 32'(m_chg));
    chk("sel_chg1", 32'(chg1), 32'(m_chg));
    chk("chg_cnt8", 32'(cnt8), 32'(m_cnt8));
    chk("chg_cnt1", 32'(cnt1), 32'(m_cnt1));
  endtask

  // One clock: capture pre-edge inputs, advance the model, check 1 ns later.
  task automatic tick();
    int  s;
    bit  e, r, changed;
    int  v8, v1;
    s  = int'(sel);
    e  = en;
    r  = rst_n;
    v8 = int'(d8[s]);
    v1 = int'(d1[s]);
    @(posedge clk);
    if (r) begin
      if (e) begin
        changed = (s != m_sel_q);
        m_yq8   = v8;
        m_yq1   = v1;
        m_sel_q = s;
        m_chg   = changed ? 1 : 0;
        if (changed) begin
          m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
          m_cnt1 = (m_cnt1 < 3)   ? m_cnt1 + 1 : 3;
        end
      end else begin
        m_chg = 0;
      end
    end else begin
      model_reset();
    end
    #1;
    check_all();
  endtask

  // Assert reset between edges and check it takes effect before any edge.
  task automatic reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_data8(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    d8[0] = a; d8[1] = b; d8[2] = c; d8[3] = d;
  endtask

  initial begin
    int wide;
    rst_n = 1'b0;
    en    = 1'b0;
    sel   = 2'b00;
    set_data8(8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) d1[i] = 1'b0;
    model_reset();

    // Combinational path during reset, including truncated select.
    d1[0] = 1'b0; d1[1] = 1'b1; d1[2] = 1'b0; d1[3] = 1'b0;
    wide = 10;
    sel  = wide[1:0];
    #1;
    chk("trunc_y", 32'(y1), 32'(0));
    chk("trunc_onehot", 32'(oh1), 32'(4'b0100));
    check_all();
    sel = 2'b01;
    #1;
    chk("sel01_y", 32'(y1), 32'(1));
    check_all();

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    // Select sweep: 00, 01, 10, 11, one per clock.
    set_data8(8'h11, 8'h22, 8'h33, 8'h44);
    en  = 1'b1;
    sel = 2'b00;
    tick();
    for (int s = 1; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("sweep_y", 32'(y8), 32'(8'h11 * (s + 1)));
      tick();
      chk("sweep_pulse", 32'(chg8), 32'(1));
    end
    chk("sweep_yq", 32'(y_q8), 32'(8'h44));
    chk("sweep_cnt", 32'(cnt8), 32'(3));

    // Constant select, toggling data.
    sel = 2'b01;
    tick();
    for (int i = 0; i < 4; i++) begin
      d8[1] = ~d8[1];
      d1[1] = ~d1[1];
      tick();
      chk("toggle_nochg", 32'(chg8), 32'(0));
    end

    // Change while disabled, then enable.
    sel = 2'b00;
    tick();
    en  = 1'b0;
    sel = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    en = 1'b1;
    tick();
    chk("en_yq", 32'(y_q8), 32'(8'h44));
    chk("en_pulse", 32'(chg8), 32'(1));
    tick();
    chk("en_pulse_once", 32'(chg8), 32'(0));

    // Saturation of the 2-bit counter after a fresh reset.
    reset_mid();
    for (int i = 0; i < 6; i++) begin
      sel = 2'(i % 2);
      tick();
    end
    chk("sat_cnt1", 32'(cnt1), 32'(3));

    // Randomised run with occasional disables and mid-cycle resets.
    for (int i = 0; i < 1500; i++) begin
      sel = 2'($urandom_range(0, 3));
      en  = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < 4; k++) begin
        d8[k] = 8'($urandom);
        d1[k] = 1'($urandom);
      end
      if ($urandom_range(0, 199) == 0) reset_mid();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
